// File: rtl/command_arbiter.sv
// rtl/command_arbiter.sv - button/clap command arbiter with pending flags, round-robin set grant and guard window
// Inc/dec requests are served before set requests; each set opens a GUARD_CYCLES busy window.
module command_arbiter #(
    parameter int GUARD_CYCLES = 16,
    parameter int STATE_MAX    = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       btnu_i,
    input  logic       btnd_i,
    input  logic       btnl_i,
    input  logic       btnr_i,
    input  logic       btnc_i,
    input  logic       clap_set_i,
    output logic       rst_o,
    output logic       set_o,
    output logic [2:0] state_o,
    output logic       set_src_o,
    output logic       busy_o,
    output logic       lock_o,
    output logic       drop_o
);

    localparam int CW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
    localparam logic [CW-1:0] GUARD_LOAD = CW'(GUARD_CYCLES - 1);
    localparam logic [2:0]    SMAX       = 3'(STATE_MAX);

    typedef enum logic {IDLE, GUARD} fsm_t;

    fsm_t          fsm_q, fsm_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pend_inc_q, pend_inc_d;
    logic          pend_dec_q, pend_dec_d;
    logic          pend_bset_q, pend_bset_d;
    logic          pend_cset_q, pend_cset_d;
    logic          rr_clap_q, rr_clap_d;
    logic [2:0]    state_d;
    logic          set_src_d, lock_d, rst_d, set_d, busy_d, drop_d;
    logic          grant_clap;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fsm_q       <= IDLE;
            cnt_q       <= '0;
            pend_inc_q  <= 1'b0;
            pend_dec_q  <= 1'b0;
            pend_bset_q <= 1'b0;
            pend_cset_q <= 1'b0;
            rr_clap_q   <= 1'b0;
            state_o     <= 3'd0;
            set_src_o   <= 1'b0;
            lock_o      <= 1'b0;
            rst_o       <= 1'b0;
            set_o       <= 1'b0;
            busy_o      <= 1'b0;
            drop_o      <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            cnt_q       <= cnt_d;
            pend_inc_q  <= pend_inc_d;
            pend_dec_q  <= pend_dec_d;
            pend_bset_q <= pend_bset_d;
            pend_cset_q <= pend_cset_d;
            rr_clap_q   <= rr_clap_d;
            state_o     <= state_d;
            set_src_o   <= set_src_d;
            lock_o      <= lock_d;
            rst_o       <= rst_d;
            set_o       <= set_d;
            busy_o      <= busy_d;
            drop_o      <= drop_d;
        end
    end

    always_comb begin
        fsm_d       = fsm_q;
        cnt_d       = cnt_q;
        pend_inc_d  = pend_inc_q;
        pend_dec_d  = pend_dec_q;
        pend_bset_d = pend_bset_q;
        pend_cset_d = pend_cset_q;
        rr_clap_d   = rr_clap_q;
        state_d     = state_o;
        set_src_d   = set_src_o;
        lock_d      = lock_o;
        rst_d       = 1'b0;
        set_d       = 1'b0;
        drop_d      = 1'b0;
        grant_clap  = 1'b0;

        if (btnd_i) begin
            // Datapath reset wins over everything sampled on the same edge, silently.
            rst_d       = 1'b1;
            pend_inc_d  = 1'b0;
            pend_dec_d  = 1'b0;
            pend_bset_d = 1'b0;
            pend_cset_d = 1'b0;
            fsm_d       = IDLE;
            cnt_d       = '0;
        end else begin
            lock_d      = lock_o ^ btnu_i;
            pend_inc_d  = pend_inc_q | btnr_i;
            pend_dec_d  = pend_dec_q | btnl_i;
            pend_bset_d = pend_bset_q | btnc_i;
            pend_cset_d = pend_cset_q | (clap_set_i & ~lock_o);
            drop_d      = (btnr_i & pend_inc_q) | (btnl_i & pend_dec_q) |
                          (btnc_i & pend_bset_q) |
                          (clap_set_i & (pend_cset_q | lock_o));

            // Service decisions use the flags as they stood before this edge.
            case (fsm_q)
                IDLE: begin
                    if (pend_inc_q || pend_dec_q) begin
                        pend_inc_d = 1'b0;
                        pend_dec_d = 1'b0;
                        if (pend_inc_q && !pend_dec_q)
                            state_d = (state_o == SMAX) ? 3'd0 : state_o + 3'd1;
                        else if (pend_dec_q && !pend_inc_q)
                            state_d = (state_o == 3'd0) ? SMAX : state_o - 3'd1;
                    end else if (pend_bset_q || pend_cset_q) begin
                        grant_clap = pend_cset_q & (~pend_bset_q | rr_clap_q);
                        set_d      = 1'b1;
                        set_src_d  = grant_clap;
                        rr_clap_d  = ~grant_clap;
                        if (grant_clap)
                            pend_cset_d = 1'b0;
                        else
                            pend_bset_d = 1'b0;
                        cnt_d      = GUARD_LOAD;
                        fsm_d      = GUARD;
                    end
                end
                GUARD: begin
                    if (cnt_q == '0)
                        fsm_d = IDLE;
                    else
                        cnt_d = cnt_q - 1'b1;
                end
                default: fsm_d = IDLE;
            endcase
        end

        busy_d = (fsm_d == GUARD);
    end

endmodule

// File: tb/tb_command_arbiter.sv
// tb/tb_command_arbiter.sv - scoreboard bench for command_arbiter
module tb_command_arbiter;

    localparam int EV_STATE = 1;
    localparam int EV_SET   = 2;
    localparam int EV_DROP  = 3;
    localparam int EV_RST   = 4;

    localparam logic [5:0] B_U = 6'b100000;
    localparam logic [5:0] B_D = 6'b010000;
    localparam logic [5:0] B_L = 6'b001000;
    localparam logic [5:0] B_R = 6'b000100;
    localparam logic [5:0] B_C = 6'b000010;
    localparam logic [5:0] B_K = 6'b000001;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic [5:0] btn = 6'b0;
    logic       rst_o, set_o, set_src_o, busy_o, lock_o, drop_o;
    logic [2:0] state_o;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    logic [2:0] prev_state = 3'd0;

    command_arbiter #(.GUARD_CYCLES(16), .STATE_MAX(4)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .btnu_i(btn[5]), .btnd_i(btn[4]), .btnl_i(btn[3]),
        .btnr_i(btn[2]), .btnc_i(btn[1]), .clap_set_i(btn[0]),
        .rst_o(rst_o), .set_o(set_o), .state_o(state_o), .set_src_o(set_src_o),
        .busy_o(busy_o), .lock_o(lock_o), .drop_o(drop_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic expect_ev(input int kind, input int val);
        exp_q.push_back(kind * 256 + val);
    endtask

    task automatic sb_pop(input string tag, input int kind, input int val);
        int e;
        e = (exp_q.size() == 0) ? 32'hFFFF : exp_q.pop_front();
        check(tag, kind * 256 + val, e);
    endtask

    always @(negedge clk) begin
        if (rst_i) begin
            prev_state = state_o;
        end else begin
            if (state_o != prev_state) sb_pop("sb_state", EV_STATE, int'(state_o));
            prev_state = state_o;
            if (set_o)  sb_pop("sb_set", EV_SET, int'(set_src_o));
            if (drop_o) sb_pop("sb_drop", EV_DROP, 0);
            if (rst_o)  sb_pop("sb_rst", EV_RST, 0);
        end
    end

    task automatic pulse(input logic [5:0] v);
        @(posedge clk); #1 btn = v;
        @(posedge clk); #1 btn = 6'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int busy_len;
        int bound;

        repeat (2) @(posedge clk);
        #1;
        check("reset_outs", {rst_o, set_o, set_src_o, busy_o, lock_o, drop_o}, 0);
        check("reset_state", state_o, 0);
        rst_i = 1'b0;

        // first pulse right after reset release, also checks inc latency
        expect_ev(EV_STATE, 1);
        pulse(B_R);
        check("inc_latency_before", state_o, 0);
        wait_cycles(1);
        check("inc_latency_after", state_o, 1);
        wait_cycles(2);

        // 2,3 then back down: 1 2 3 2 1 sequence continues from 1
        expect_ev(EV_STATE, 2); pulse(B_R); wait_cycles(2);
        expect_ev(EV_STATE, 3); pulse(B_R); wait_cycles(2);
        expect_ev(EV_STATE, 2); pulse(B_L); wait_cycles(2);
        expect_ev(EV_STATE, 1); pulse(B_L); wait_cycles(2);
        check("steps_state", state_o, 1);

        // wrap both ways at STATE_MAX
        for (int s = 2; s <= 4; s++) begin
            expect_ev(EV_STATE, s); pulse(B_R); wait_cycles(2);
        end
        expect_ev(EV_STATE, 0); pulse(B_R); wait_cycles(2);
        check("wrap_up", state_o, 0);
        expect_ev(EV_STATE, 4); pulse(B_L); wait_cycles(2);
        check("wrap_down", state_o, 4);

        // simultaneous inc+dec cancel
        pulse(B_R | B_L); wait_cycles(2);
        check("inc_dec_cancel", state_o, 4);

        // duplicate inc on consecutive edges: second one dropped
        expect_ev(EV_STATE, 0);
        expect_ev(EV_DROP, 0);
        @(posedge clk); #1 btn = B_R;
        @(posedge clk); #1 btn = B_R;
        @(posedge clk); #1 btn = 6'b0;
        wait_cycles(3);
        check("dup_drop_state", state_o, 0);

        // button + clap same edge: button first, 16 busy cycles, then clap
        expect_ev(EV_SET, 0);
        expect_ev(EV_SET, 1);
        pulse(B_C | B_K);
        check("set_latency_before", set_o, 0);
        wait_cycles(1);
        check("set_latency_after", set_o, 1);
        busy_len = 0;
        bound = 0;
        while (busy_o && bound < 40) begin
            busy_len++;
            bound++;
            wait_cycles(1);
        end
        check("guard_len", busy_len, 16);
        wait_cycles(1);
        check("second_guard_busy", busy_o, 1);
        wait_cycles(20);
        check("after_guards_busy", busy_o, 0);

        // lock blocks clap
        pulse(B_U);
        check("lock_on", lock_o, 1);
        expect_ev(EV_DROP, 0);
        pulse(B_K);
        wait_cycles(20);
        check("lock_held", lock_o, 1);

        // datapath reset mid-guard with clap pending
        pulse(B_U);
        check("lock_off", lock_o, 0);
        expect_ev(EV_SET, 0);
        pulse(B_C);
        wait_cycles(3);
        pulse(B_K);
        expect_ev(EV_RST, 0);
        pulse(B_D);
        check("btnd_rst_o", rst_o, 1);
        check("btnd_busy_low", busy_o, 0);
        wait_cycles(1);
        check("btnd_rst_one_cycle", rst_o, 0);
        wait_cycles(30);
        check("btnd_state_kept", state_o, 0);

        // reach state 3, then async reset in the middle of a guard window
        expect_ev(EV_STATE, 4); pulse(B_L); wait_cycles(2);
        expect_ev(EV_STATE, 3); pulse(B_L); wait_cycles(2);
        pulse(B_U);
        expect_ev(EV_SET, 0);
        pulse(B_C);
        wait_cycles(5);
        check("pre_rst_busy", busy_o, 1);
        check("pre_rst_state", state_o, 3);
        check("pre_rst_lock", lock_o, 1);
        @(negedge clk);
        #2 rst_i = 1'b1;
        #1;
        check("async_rst_outs", {rst_o, set_o, set_src_o, busy_o, lock_o, drop_o}, 0);
        check("async_rst_state", state_o, 0);
        wait_cycles(2);
        rst_i = 1'b0;
        wait_cycles(20);
        check("post_rst_idle", busy_o, 0);

        check("sb_leftover", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
